sap_1_controller_sequencer: RTL and testbench

- Timing and control unit of the SAP-1 CPU, directly downstream of the instruction decoder.
- Runs the T-state ring sequence (fetch T1-T3, execute T4-T6) and combines the current T-state with the decoder's one-hot LDA/ADD/SUB/OUT/HLT lines.
- Drives the 12-bit control word to the PC, MAR, RAM, IR, accumulator, adder/subtracter, B and output registers.
- Stops the sequence permanently on HLT until reset.

---
 rtl/sap_1_controller_sequencer.sv | 115 +++++++++++
 tb/tb_sap_1_controller_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 timing and control: one-hot T-state ring plus combinational control-word
// decode from the current T-state and the instruction decoder lines.
module sap_1_controller_sequencer #(
  parameter int SKIP_NOP = 0
) (
  input  logic       CLK,
  input  logic       CLR_n,
  input  logic       LDA,
  input  logic       ADD,
  input  logic       SUB,
  input  logic       OUT,
  input  logic       HLT,
  output logic [5:0] T,
  output logic       HALTED,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm_n,
  output logic       CE_n,
  output logic       Li_n,
  output logic       Ei_n,
  output logic       La_n,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb_n,
  output logic       Lo_n
);

  // One-hot encoding so T and HALTED come straight off flop outputs, glitch-free.
  localparam logic [7:0] S_IDLE = 8'b0000_0001;
  localparam logic [7:0] S_T1   = 8'b0000_0010;
  localparam logic [7:0] S_T2   = 8'b0000_0100;
  localparam logic [7:0] S_T3   = 8'b0000_1000;
  localparam logic [7:0] S_T4   = 8'b0001_0000;
  localparam logic [7:0] S_T5   = 8'b0010_0000;
  localparam logic [7:0] S_T6   = 8'b0100_0000;
  localparam logic [7:0] S_HALT = 8'b1000_0000;

  logic [7:0] state_q;
  logic [7:0] state_d;

  logic t1, t2, t3, t4, t5, t6;
  logic op_hlt, op_out, op_sub, op_add, op_lda, op_nop;
  logic op_mem, op_alu;

  // Priority resolution of illegal multi-hot decoder input: HLT > OUT > SUB > ADD > LDA.
  assign op_hlt = HLT;
  assign op_out = OUT & ~HLT;
  assign op_sub = SUB & ~OUT & ~HLT;
  assign op_add = ADD & ~SUB & ~OUT & ~HLT;
  assign op_lda = LDA & ~ADD & ~SUB & ~OUT & ~HLT;
  assign op_nop = ~(LDA | ADD | SUB | OUT | HLT);

  assign op_alu = op_add | op_sub;
  assign op_mem = op_lda | op_alu;

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = S_T4;
      S_T4: begin
        if (op_hlt)
          state_d = S_HALT;
        else if ((SKIP_NOP != 0) && (op_out | op_nop))
          state_d = S_T1;
        else
          state_d = S_T5;
      end
      S_T5: begin
        if ((SKIP_NOP != 0) && !op_alu)
          state_d = S_T1;
        else
          state_d = S_T6;
      end
      S_T6:   state_d = S_T1;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  assign t1 = state_q[1];
  assign t2 = state_q[2];
  assign t3 = state_q[3];
  assign t4 = state_q[4];
  assign t5 = state_q[5];
  assign t6 = state_q[6];

  assign T      = state_q[6:1];
  assign HALTED = state_q[7];

  // Decoder lines only reach the control word through the T4-T6 terms.
  assign Ep   = t1;
  assign Cp   = t2;
  assign Lm_n = ~(t1 | (t4 & op_mem));
  assign CE_n = ~(t3 | (t5 & op_mem));
  assign Li_n = ~t3;
  assign Ei_n = ~(t4 & op_mem);
  assign La_n = ~((t5 & op_lda) | (t6 & op_alu));
  assign Ea   = t4 & op_out;
  assign Su   = (t4 | t5 | t6) & op_sub;
  assign Eu   = t6 & op_alu;
  assign Lb_n = ~(t5 & op_alu);
  assign Lo_n = ~(t4 & op_out);

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// Bench for the SAP-1 controller/sequencer: directed vector table, hand-written
// halt/reset sequences, and random decoder/reset stimulus against a micro-op model.
module tb_sap_1_controller_sequencer;

  localparam logic [11:0] B_CP = 12'h800, B_EP = 12'h400, B_LM = 12'h200, B_CE = 12'h100;
  localparam logic [11:0] B_LI = 12'h080, B_EI = 12'h040, B_LA = 12'h020, B_EA = 12'h010;
  localparam logic [11:0] B_SU = 12'h008, B_EU = 12'h004, B_LB = 12'h002, B_LO = 12'h001;
  localparam logic [11:0] INACT = 12'h3E3;

  localparam logic [4:0] L_0   = 5'b00000;
  localparam logic [4:0] L_LDA = 5'b00001;
  localparam logic [4:0] L_ADD = 5'b00010;
  localparam logic [4:0] L_SUB = 5'b00100;
  localparam logic [4:0] L_OUT = 5'b01000;
  localparam logic [4:0] L_HLT = 5'b10000;

  logic       clk = 1'b0;
  logic       CLR_n = 1'b0;
  logic [4:0] ln = '0;

  logic [5:0] T0, T1;
  logic       H0, H1;
  logic       Cp0, Ep0, Lm0, CE0, Li0, Ei0, La0, Ea0, Su0, Eu0, Lb0, Lo0;
  logic       Cp1, Ep1, Lm1, CE1, Li1, Ei1, La1, Ea1, Su1, Eu1, Lb1, Lo1;
  logic [18:0] obs0, obs1;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sap_1_controller_sequencer #(.SKIP_NOP(0)) dut0 (
    .CLK(clk), .CLR_n(CLR_n),
    .LDA(ln[0]), .ADD(ln[1]), .SUB(ln[2]), .OUT(ln[3]), .HLT(ln[4]),
    .T(T0), .HALTED(H0),
    .Cp(Cp0), .Ep(Ep0), .Lm_n(Lm0), .CE_n(CE0), .Li_n(Li0), .Ei_n(Ei0),
    .La_n(La0), .Ea(Ea0), .Su(Su0), .Eu(Eu0), .Lb_n(Lb0), .Lo_n(Lo0)
  );

  sap_1_controller_sequencer #(.SKIP_NOP(1)) dut1 (
    .CLK(clk), .CLR_n(CLR_n),
    .LDA(ln[0]), .ADD(ln[1]), .SUB(ln[2]), .OUT(ln[3]), .HLT(ln[4]),
    .T(T1), .HALTED(H1),
    .Cp(Cp1), .Ep(Ep1), .Lm_n(Lm1), .CE_n(CE1), .Li_n(Li1), .Ei_n(Ei1),
    .La_n(La1), .Ea(Ea1), .Su(Su1), .Eu(Eu1), .Lb_n(Lb1), .Lo_n(Lo1)
  );

  assign obs0 = {T0, H0, Cp0, Ep0, Lm0, CE0, Li0, Ei0, La0, Ea0, Su0, Eu0, Lb0, Lo0};
  assign obs1 = {T1, H1, Cp1, Ep1, Lm1, CE1, Li1, Ei1, La1, Ea1, Su1, Eu1, Lb1, Lo1};

  // Micro-op table per instruction (0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 OUT, 5 HLT), steps 1..6.
  logic [11:0] uop [0:5][1:6];

  function automatic logic [18:0] pack(input int tidx, input logic [11:0] mask, input logic halt);
    logic [5:0] tv;
    tv = '0;
    if (tidx >= 1 && tidx <= 6) tv[tidx-1] = 1'b1;
    return {tv, halt, mask ^ INACT};
  endfunction

  function automatic int winner(input logic [4:0] l);
    if (l[4]) return 5;
    if (l[3]) return 4;
    if (l[2]) return 3;
    if (l[1]) return 2;
    if (l[0]) return 1;
    return 0;
  endfunction

  // Machine-cycle length: 6, or with skipping the last step carrying any micro-op (at least 4).
  function automatic int cyc_len(input int op, input int skip);
    if (skip == 0) return 6;
    for (int s = 6; s >= 5; s--)
      if (uop[op][s] != 12'h000) return s;
    return 4;
  endfunction

  function automatic int nxt(input int t, input logic [4:0] l, input int skip);
    int op;
    op = winner(l);
    if (t == 7) return 7;
    if (t == 0) return 1;
    if (t == 4 && op == 5) return 7;
    if (t >= cyc_len(op, skip)) return 1;
    return t + 1;
  endfunction

  function automatic logic [18:0] model_exp(input int t, input logic [4:0] l);
    logic [11:0] m;
    m = '0;
    if (t >= 1 && t <= 6) m = uop[winner(l)][t];
    return pack(t, m, t == 7);
  endfunction

  task automatic chk(input int dut, input string name, input logic [18:0] exp);
    logic [18:0] act;
    act = (dut == 0) ? obs0 : obs1;
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got {T,HALTED,cw}=%h, expected %h", name, dut, act, exp);
    end
  endtask

  typedef struct {
    int          dut;
    logic        clr_n;
    logic [4:0]  ln;
    int          tidx;
    logic [11:0] mask;
    logic        halt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int dut, input logic clr, input logic [4:0] l, input int tidx,
                     input logic [11:0] m, input logic h);
    vec_t v;
    v.dut = dut; v.clr_n = clr; v.ln = l; v.tidx = tidx; v.mask = m; v.halt = h;
    vq.push_back(v);
  endtask

  task automatic add_fetch(input int dut, input logic [4:0] l);
    add(dut, 1'b1, l, 1, B_EP | B_LM, 1'b0);
    add(dut, 1'b1, l, 2, B_CP, 1'b0);
    add(dut, 1'b1, l, 3, B_CE | B_LI, 1'b0);
  endtask

  task automatic both(input string name, input int tidx, input logic [11:0] m, input logic h);
    chk(0, name, pack(tidx, m, h));
    chk(1, name, pack(tidx, m, h));
  endtask

  initial begin
    int m0, m1;
    logic any_halt;

    for (int i = 0; i <= 5; i++) begin
      uop[i][1] = B_EP | B_LM;
      uop[i][2] = B_CP;
      uop[i][3] = B_CE | B_LI;
      for (int s = 4; s <= 6; s++) uop[i][s] = 12'h000;
    end
    uop[1][4] = B_EI | B_LM;  uop[1][5] = B_CE | B_LA;
    uop[2][4] = B_EI | B_LM;  uop[2][5] = B_CE | B_LB;  uop[2][6] = B_EU | B_LA;
    uop[3][4] = B_EI | B_LM | B_SU;  uop[3][5] = B_CE | B_LB | B_SU;  uop[3][6] = B_EU | B_LA | B_SU;
    uop[4][4] = B_EA | B_LO;

    // Fixed 6-state cycle: reset, NOP, ADD, SUB, OUT+SUB priority, LDA, HLT.
    for (int i = 0; i < 3; i++) add(0, 1'b0, L_0, 0, 12'h000, 1'b0);
    add(0, 1'b1, L_0, 0, 12'h000, 1'b0);
    add_fetch(0, L_0);
    add(0, 1'b1, L_0, 4, 12'h000, 1'b0);
    add(0, 1'b1, L_0, 5, 12'h000, 1'b0);
    add(0, 1'b1, L_0, 6, 12'h000, 1'b0);
    add(0, 1'b1, L_HLT, 1, B_EP | B_LM, 1'b0);
    add(0, 1'b1, L_OUT, 2, B_CP, 1'b0);
    add(0, 1'b1, L_ADD, 3, B_CE | B_LI, 1'b0);
    add(0, 1'b1, L_ADD, 4, B_EI | B_LM, 1'b0);
    add(0, 1'b1, L_ADD, 5, B_CE | B_LB, 1'b0);
    add(0, 1'b1, L_ADD, 6, B_EU | B_LA, 1'b0);
    add_fetch(0, L_0);
    add(0, 1'b1, L_SUB, 4, B_EI | B_LM | B_SU, 1'b0);
    add(0, 1'b1, L_SUB, 5, B_CE | B_LB | B_SU, 1'b0);
    add(0, 1'b1, L_SUB, 6, B_EU | B_LA | B_SU, 1'b0);
    add_fetch(0, L_0);
    add(0, 1'b1, L_OUT | L_SUB, 4, B_EA | B_LO, 1'b0);
    add(0, 1'b1, L_OUT | L_SUB, 5, 12'h000, 1'b0);
    add(0, 1'b1, L_OUT | L_SUB, 6, 12'h000, 1'b0);
    add_fetch(0, L_0);
    add(0, 1'b1, L_LDA, 4, B_EI | B_LM, 1'b0);
    add(0, 1'b1, L_LDA, 5, B_CE | B_LA, 1'b0);
    add(0, 1'b1, L_LDA, 6, 12'h000, 1'b0);
    add_fetch(0, L_0);
    add(0, 1'b1, L_LDA | L_ADD, 4, B_EI | B_LM, 1'b0);
    add(0, 1'b1, L_LDA | L_ADD, 5, B_CE | B_LB, 1'b0);
    add(0, 1'b1, L_LDA | L_ADD, 6, B_EU | B_LA, 1'b0);
    add_fetch(0, L_0);
    add(0, 1'b1, L_HLT, 4, 12'h000, 1'b0);
    add(0, 1'b1, L_HLT, 0, 12'h000, 1'b1);
    add(0, 1'b1, L_0, 0, 12'h000, 1'b1);
    // Variable-length cycle: OUT and NOP end at T4, LDA at T5, ADD runs to T6.
    add(1, 1'b0, L_0, 0, 12'h000, 1'b0);
    add(1, 1'b1, L_0, 0, 12'h000, 1'b0);
    add_fetch(1, L_0);
    add(1, 1'b1, L_OUT, 4, B_EA | B_LO, 1'b0);
    add_fetch(1, L_0);
    add(1, 1'b1, L_LDA, 4, B_EI | B_LM, 1'b0);
    add(1, 1'b1, L_LDA, 5, B_CE | B_LA, 1'b0);
    add_fetch(1, L_0);
    add(1, 1'b1, L_0, 4, 12'h000, 1'b0);
    add_fetch(1, L_0);
    add(1, 1'b1, L_ADD, 4, B_EI | B_LM, 1'b0);
    add(1, 1'b1, L_ADD, 5, B_CE | B_LB, 1'b0);
    add(1, 1'b1, L_ADD, 6, B_EU | B_LA, 1'b0);
    add(1, 1'b1, L_0, 1, B_EP | B_LM, 1'b0);

    foreach (vq[i]) begin
      @(negedge clk);
      CLR_n = vq[i].clr_n;
      ln    = vq[i].ln;
      #1;
      chk(vq[i].dut, $sformatf("vec%0d", i), pack(vq[i].tidx, vq[i].mask, vq[i].halt));
    end

    // HALT is absorbing for 20 clocks; only an asynchronous clear leaves it.
    @(negedge clk); CLR_n = 1'b0; ln = L_0;
    @(negedge clk); CLR_n = 1'b1;
    repeat (4) @(negedge clk);
    ln = L_HLT;
    #1 both("halt_t4", 4, 12'h000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ln = L_0;
      #1 both($sformatf("halt_hold%0d", i), 0, 12'h000, 1'b1);
    end
    #2 CLR_n = 1'b0;
    #1 both("halt_async_clr", 0, 12'h000, 1'b0);
    @(negedge clk); CLR_n = 1'b1;
    #1 both("halt_idle", 0, 12'h000, 1'b0);
    @(negedge clk);
    #1 both("halt_restart_t1", 1, B_EP | B_LM, 1'b0);

    // Clear dropped between edges during T5 of ADD.
    ln = L_ADD;
    repeat (4) @(negedge clk);
    #1 both("add_t5", 5, B_CE | B_LB, 1'b0);
    #1 CLR_n = 1'b0;
    #1 both("add_t5_async_clr", 0, 12'h000, 1'b0);
    @(negedge clk); CLR_n = 1'b1; ln = L_0;
    @(negedge clk);
    #1 both("add_restart_t1", 1, B_EP | B_LM, 1'b0);

    // Random decoder lines and clears against the micro-op model.
    @(negedge clk); CLR_n = 1'b0;
    m0 = 0; m1 = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      any_halt = (m0 == 7) || (m1 == 7);
      if ($urandom_range(0, 59) == 0 || (any_halt && $urandom_range(0, 7) == 0))
        CLR_n = 1'b0;
      else
        CLR_n = 1'b1;
      if (!CLR_n) begin
        m0 = 0;
        m1 = 0;
      end
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: ln = L_0;
          1: ln = 5'(5'b00001 << $urandom_range(0, 3));
          2: ln = ($urandom_range(0, 9) == 0) ? L_HLT : L_ADD;
          default: ln = 5'($urandom_range(0, 31));
        endcase
      end
      #1;
      chk(0, $sformatf("rand%0d", c), model_exp(m0, ln));
      chk(1, $sformatf("rand%0d", c), model_exp(m1, ln));
      if (CLR_n) begin
        m0 = nxt(m0, ln, 0);
        m1 = nxt(m1, ln, 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
